// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state
// encoding, stream framing constants and a header-size helper.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Stream bytes that make up one 32-bit instruction word.
    localparam int unsigned BYTES_PER_WORD = 4;

    // Number of bytes in the little-endian word-count header.
    function automatic int unsigned hdr_bytes(input int unsigned len_w);
        return len_w / 8;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words. The newest byte
// always enters at the top, so after four shifts byte 0 sits in [7:0].
// o_word is the word as it will look once the byte on i_byte is taken,
// so the FSM can latch a complete word on the same edge as the 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    assign o_word      = {i_byte, r_shift};
    assign o_word_full = i_shift && (r_cnt == 2'(BYTES_PER_WORD - 1));

    // Byte shift register and position counter; cleared between words.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (i_clear) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (i_shift) begin
            r_shift <= o_word[31:8];
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program image into the instruction BRAM write port from a
// valid/ready byte stream: a little-endian word-count header followed by
// that many little-endian 32-bit words. Holds the CPU while loading.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [31:0]       o_bram_din,
    output logic              o_bram_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_cpu_hold
);

    localparam int HDR_BYTES = int'(hdr_bytes(LEN_W));
    localparam int HDR_CNT_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    // Wide enough to hold both the header value and the memory depth,
    // so that a header equal to the depth is neither truncated nor wrapped.
    localparam int CMP_W     = ((LEN_W > ADDR_W) ? LEN_W : ADDR_W) + 1;
    localparam logic [CMP_W-1:0] DEPTH = CMP_W'(1) << ADDR_W;

    state_t                r_state;
    logic [HDR_CNT_W-1:0]  r_hdr_cnt;
    logic [LEN_W-9:0]      r_len_lo;
    logic [CMP_W-1:0]      r_last;
    logic [ADDR_W-1:0]     r_index;
    logic                  r_byte_ready;
    logic [ADDR_W-1:0]     r_bram_addr;
    logic [31:0]           r_bram_din;
    logic                  r_bram_we;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_pack_clear;
    logic                  w_pack_shift;
    logic [31:0]           w_word;
    logic                  w_word_full;
    logic [LEN_W-1:0]      w_len_next;
    logic [CMP_W-1:0]      w_len_cmp;
    logic                  w_arm;

    assign w_accept     = i_byte_valid && r_byte_ready;
    assign w_arm        = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_pack_clear = w_arm || (r_state == ST_WRITE);
    assign w_pack_shift = w_accept && (r_state == ST_DATA);
    // Header arrives LSB first: each new byte enters at the top.
    assign w_len_next   = {i_byte_data, r_len_lo};
    assign w_len_cmp    = CMP_W'(w_len_next);

    byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_pack_clear),
        .i_shift     (w_pack_shift),
        .i_byte      (i_byte_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    // Load sequencer with all outputs registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_hdr_cnt    <= '0;
            r_len_lo     <= '0;
            r_last       <= '0;
            r_index      <= '0;
            r_byte_ready <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_din   <= 32'd0;
            r_bram_we    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state      <= ST_LEN;
                        r_hdr_cnt    <= '0;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
                ST_LEN: begin
                    if (w_accept) begin
                        r_len_lo <= w_len_next[LEN_W-1:8];
                        if (r_hdr_cnt == HDR_CNT_W'(HDR_BYTES - 1)) begin
                            if (w_len_cmp == CMP_W'(0)) begin
                                r_state      <= ST_DONE;
                                r_byte_ready <= 1'b0;
                                r_busy       <= 1'b0;
                                r_done       <= 1'b1;
                                r_error      <= 1'b0;
                            end else if (w_len_cmp > DEPTH) begin
                                r_state      <= ST_DONE;
                                r_byte_ready <= 1'b0;
                                r_busy       <= 1'b0;
                                r_done       <= 1'b1;
                                r_error      <= 1'b1;
                            end else begin
                                r_state <= ST_DATA;
                                r_index <= '0;
                                r_last  <= w_len_cmp - CMP_W'(1);
                            end
                        end else begin
                            r_hdr_cnt <= r_hdr_cnt + HDR_CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_word_full) begin
                        r_state      <= ST_WRITE;
                        r_byte_ready <= 1'b0;
                        r_bram_we    <= 1'b1;
                        r_bram_addr  <= r_index;
                        r_bram_din   <= w_word;
                    end
                end
                ST_WRITE: begin
                    r_bram_we <= 1'b0;
                    if (CMP_W'(r_index) == r_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= ST_DATA;
                        r_index      <= r_index + ADDR_W'(1);
                        r_byte_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                    r_bram_we    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_error      <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_bram_addr  = r_bram_addr;
    assign o_bram_din   = r_bram_din;
    assign o_bram_we    = r_bram_we;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_cpu_hold   = r_busy;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader (built with a 16-word memory).
// The driver derives the expected BRAM writes and load outcome from the
// image it sends; a negedge monitor pops and compares as the DUT acts.
module tb_instruction_loader;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              bv = 1'b0;
    logic [7:0]        bd = 8'd0;
    logic              o_byte_ready;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [31:0]       o_bram_din;
    logic              o_bram_we;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic              o_cpu_hold;

    instruction_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_byte_valid (bv),
        .i_byte_data  (bd),
        .o_byte_ready (o_byte_ready),
        .o_bram_addr  (o_bram_addr),
        .o_bram_din   (o_bram_din),
        .o_bram_we    (o_bram_we),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_cpu_hold   (o_cpu_hold)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit gap_mode = 1'b0;

    logic [ADDR_W+31:0] exp_wr[$];   // {addr, data}
    logic [1:0]         exp_done[$]; // {error, had_writes}
    logic [31:0]        img [DEPTH];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every write and every load completion.
    logic prev_we = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        logic [ADDR_W+31:0] w;
        logic [1:0] d;
        chk("cpu_hold_eq_busy", 64'(o_cpu_hold), 64'(o_busy));
        if (o_bram_we) begin
            chk("we_single_cycle", 64'(prev_we), 64'd0);
            chk("ready_low_in_write", 64'(o_byte_ready), 64'd0);
            chk("write_expected", 64'(exp_wr.size() > 0), 64'd1);
            if (exp_wr.size() > 0) begin
                w = exp_wr.pop_front();
                chk("bram_addr", 64'(o_bram_addr), 64'(w[ADDR_W+31:32]));
                chk("bram_din", 64'(o_bram_din), 64'(w[31:0]));
            end
        end
        if (o_done && !prev_done) begin
            chk("done_expected", 64'(exp_done.size() > 0), 64'd1);
            if (exp_done.size() > 0) begin
                d = exp_done.pop_front();
                chk("error_flag", 64'(o_error), 64'(d[1]));
                chk("done_after_last_write", 64'(prev_we), 64'(d[0]));
            end
            chk("all_writes_seen", 64'(exp_wr.size()), 64'd0);
            chk("busy_low_at_done", 64'(o_busy), 64'd0);
        end
        prev_we = o_bram_we;
        prev_done = o_done;
    end

    function automatic logic [63:0] all_outs();
        return 64'({o_byte_ready, o_bram_addr, o_bram_din, o_bram_we,
                    o_busy, o_done, o_error, o_cpu_hold});
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit inject);
        int n;
        int w;
        n = gap_mode ? int'($urandom_range(0, 3)) : 0;
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            bv = 1'b0;
            bd = 8'($urandom);
        end
        @(negedge clk);
        start = inject;
        bv = 1'b1;
        bd = b;
        w = 0;
        while (!o_byte_ready && w < 100) begin
            @(negedge clk);
            start = 1'b0;
            w++;
        end
        chk("byte_accepted", 64'(o_byte_ready), 64'd1);
    endtask

    // Runs one load of header n over img[]; abort >= 0 resets after that many data bytes.
    task automatic run_load(input int n, input int inject_at, input int abort);
        bit has;
        bit err;
        bit stop;
        logic [15:0] h;
        int w;
        has = (n >= 1) && (n <= DEPTH);
        err = (n > DEPTH);
        h = 16'(n);
        exp_done.push_back({err, has});
        if (has) for (int i = 0; i < n; i++) exp_wr.push_back({ADDR_W'(i), img[i]});
        @(negedge clk);
        start = 1'b1;
        bv = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'd1);
        chk("ready_after_start", 64'(o_byte_ready), 64'd1);
        chk("done_cleared_by_start", 64'(o_done), 64'd0);
        send_byte(h[7:0], 1'b0);
        send_byte(h[15:8], 1'b0);
        stop = 1'b0;
        if (has) begin
            for (int i = 0; i < n && !stop; i++) begin
                for (int k = 0; k < 4 && !stop; k++) begin
                    if (abort >= 0 && i * 4 + k >= abort) stop = 1'b1;
                    else send_byte(img[i][8*k +: 8], (i * 4 + k) == inject_at);
                end
            end
        end
        @(negedge clk);
        bv = 1'b0;
        start = 1'b0;
        if (abort >= 0) begin
            repeat (3) @(negedge clk);
            chk("writes_before_reset", 64'(exp_wr.size()), 64'(n - abort / 4));
            rst_n = 1'b0;
            #1;
            chk("outputs_zero_in_reset", all_outs(), 64'd0);
            exp_wr.delete();
            exp_done.delete();
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            w = 0;
            while (!o_done && w < 400) begin
                @(negedge clk);
                w++;
            end
            chk("done_reached", 64'(o_done), 64'd1);
            repeat (2) @(negedge clk);
            chk("done_held", 64'(o_done), 64'd1);
            chk("error_held", 64'(o_error), 64'(err));
        end
    endtask

    task automatic random_image();
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", all_outs(), 64'd0);

        // Two-word image from a contiguous byte stream.
        img[0] = 32'h0050_0013;
        img[1] = 32'h0010_0093;
        run_load(2, -1, -1);

        // Empty image, oversized header, then a full-depth image.
        run_load(0, -1, -1);
        run_load(17, -1, -1);
        random_image();
        run_load(16, -1, -1);

        // Same full image again with random gaps and a stray start mid-data.
        gap_mode = 1'b1;
        run_load(16, 21, -1);

        // Random lengths and contents with gaps and stray starts.
        for (int r = 0; r < 6; r++) begin
            random_image();
            n = int'($urandom_range(1, DEPTH));
            run_load(n, int'($urandom_range(0, 4 * n - 1)), -1);
        end

        // Reset after two words plus half a word, then a clean reload.
        gap_mode = 1'b0;
        random_image();
        run_load(4, -1, 10);
        chk("idle_after_reset", all_outs(), 64'd0);
        random_image();
        run_load(4, -1, -1);

        repeat (3) @(negedge clk);
        chk("no_leftover_writes", 64'(exp_wr.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
